// File: rtl/hsv_clint_timer_if.sv
// axil_if: 32-bit AXI-Lite bundle for the hsv_clint_timer register port.
//   Channels: AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//             B (bresp/bvalid/bready), AR (araddr/arvalid/arready),
//             R (rdata/rresp/rvalid/rready).
//   Modports: s = slave (timer side), m = master (interconnect/bench side).
interface axil_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport s (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport m (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/hsv_clint_timer.sv
// hsv_clint_timer: machine timer / interrupt source for hsv_core.
//   64-bit mtime counter (advanced every PRESCALE clocks while CTRL.cnt_en=1)
//   and 64-bit mtimecmp, both behind an AXI-Lite slave. irq_core is a
//   registered copy of (mtime >= mtimecmp).
// Ports:
//   clk_core   - core clock, sole clock domain
//   rst_core_n - synchronous reset, active low
//   ctrl       - axil_if.s register port
//   irq_core   - level interrupt to hsv_core
// Register map (addr[4:2]): 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO,
//   0x0C MTIMECMP_HI, 0x10 CTRL (bit0 cnt_en). Higher addresses -> SLVERR.
// Build option: define HSV_CLINT_MSIP_EN to add MSIP (bit0) at 0x14, which
//   is OR-ed into irq_core; the SLVERR boundary then moves to 0x18.
module hsv_clint_timer #(
  parameter int unsigned PRESCALE   = 1,
  parameter bit          CNT_EN_RST = 1'b1
) (
  input  logic clk_core,
  input  logic rst_core_n,
  axil_if.s    ctrl,
  output logic irq_core
);

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [15:0] PRE_MAX     = 16'(PRESCALE - 1);
`ifdef HSV_CLINT_MSIP_EN
  localparam logic [31:0] ADDR_LIMIT  = 32'h18;
`else
  localparam logic [31:0] ADDR_LIMIT  = 32'h14;
`endif

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_DATA } r_state_e;

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
    return res;
  endfunction

  w_state_e    w_state_q, w_state_d;
  r_state_e    r_state_q, r_state_d;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic        cnt_en_q, cnt_en_d;
  logic [15:0] pre_q, pre_d;
  logic        irq_q, irq_d;
`ifdef HSV_CLINT_MSIP_EN
  logic        msip_q, msip_d;
`endif

  logic        tick, aw_hs, w_hs, commit, wr_ok;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  always_comb begin
    w_state_d  = w_state_q;   r_state_d  = r_state_q;
    aw_held_d  = aw_held_q;   w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;    wdata_d    = wdata_q;    wstrb_d = wstrb_q;
    awready_d  = awready_q;   wready_d   = wready_q;   arready_d = arready_q;
    bvalid_d   = bvalid_q;    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;    rresp_d    = rresp_q;    rdata_d = rdata_q;
    mtime_d    = mtime_q;     mtimecmp_d = mtimecmp_q;
    cnt_en_d   = cnt_en_q;    pre_d      = pre_q;
`ifdef HSV_CLINT_MSIP_EN
    msip_d     = msip_q;
    irq_d      = (mtime_q >= mtimecmp_q) | msip_q;
`else
    irq_d      = (mtime_q >= mtimecmp_q);
`endif

    // Free-running prescaler; a frozen counter holds its phase.
    tick = cnt_en_q && (pre_q == PRE_MAX);
    if (cnt_en_q) pre_d = tick ? 16'd0 : pre_q + 16'd1;
    if (tick)     mtime_d = mtime_q + 64'd1;

    // A half that was accepted earlier is taken from its holding register,
    // otherwise straight from the bus so AW+W together commit in one cycle.
    aw_hs   = ctrl.awvalid & awready_q;
    w_hs    = ctrl.wvalid & wready_q;
    wr_addr = aw_held_q ? awaddr_q : ctrl.awaddr;
    wr_data = w_held_q  ? wdata_q  : ctrl.wdata;
    wr_strb = w_held_q  ? wstrb_q  : ctrl.wstrb;
    commit  = (w_state_q == W_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
    wr_ok   = wr_addr < ADDR_LIMIT;

    case (w_state_q)
      W_IDLE: begin
        if (commit) begin
          aw_held_d = 1'b0;  w_held_d = 1'b0;
          awready_d = 1'b0;  wready_d = 1'b0;
          bvalid_d  = 1'b1;  w_state_d = W_RESP;
          bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
          // mtime writes start from the pre-tick value: the written half
          // wins over a same-cycle tick and no carry crosses halves.
          if (wr_ok) begin
            case (wr_addr[4:2])
              3'd0: begin
                mtime_d = {mtime_q[63:32], merge_be(mtime_q[31:0], wr_data, wr_strb)};
                pre_d   = 16'd0;
              end
              3'd1: begin
                mtime_d = {merge_be(mtime_q[63:32], wr_data, wr_strb), mtime_q[31:0]};
                pre_d   = 16'd0;
              end
              3'd2: mtimecmp_d[31:0]  = merge_be(mtimecmp_q[31:0], wr_data, wr_strb);
              3'd3: mtimecmp_d[63:32] = merge_be(mtimecmp_q[63:32], wr_data, wr_strb);
              3'd4: if (wr_strb[0]) cnt_en_d = wr_data[0];
`ifdef HSV_CLINT_MSIP_EN
              3'd5: if (wr_strb[0]) msip_d = wr_data[0];
`endif
              default: ;
            endcase
          end
        end else begin
          if (aw_hs) begin
            aw_held_d = 1'b1;  awready_d = 1'b0;  awaddr_d = ctrl.awaddr;
          end
          if (w_hs) begin
            w_held_d = 1'b1;  wready_d = 1'b0;
            wdata_d  = ctrl.wdata;  wstrb_d = ctrl.wstrb;
          end
        end
      end
      W_RESP: begin
        if (ctrl.bready) begin
          bvalid_d  = 1'b0;  w_state_d = W_IDLE;
          awready_d = 1'b1;  wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    // Read data is sampled from the _q values, so a same-cycle write
    // commit is not visible to this read.
    case (r_state_q)
      R_IDLE: begin
        if (ctrl.arvalid && arready_q) begin
          rvalid_d  = 1'b1;  arready_d = 1'b0;  r_state_d = R_DATA;
          rdata_d   = 32'd0;
          rresp_d   = (ctrl.araddr < ADDR_LIMIT) ? RESP_OKAY : RESP_SLVERR;
          if (ctrl.araddr < ADDR_LIMIT) begin
            case (ctrl.araddr[4:2])
              3'd0: rdata_d = mtime_q[31:0];
              3'd1: rdata_d = mtime_q[63:32];
              3'd2: rdata_d = mtimecmp_q[31:0];
              3'd3: rdata_d = mtimecmp_q[63:32];
              3'd4: rdata_d = {31'd0, cnt_en_q};
`ifdef HSV_CLINT_MSIP_EN
              3'd5: rdata_d = {31'd0, msip_q};
`endif
              default: rdata_d = 32'd0;
            endcase
          end
        end
      end
      R_DATA: begin
        if (ctrl.rready) begin
          rvalid_d = 1'b0;  arready_d = 1'b1;  r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (!rst_core_n) begin
      w_state_q  <= W_IDLE;   r_state_q <= R_IDLE;
      aw_held_q  <= 1'b0;     w_held_q  <= 1'b0;
      awaddr_q   <= 32'd0;    wdata_q   <= 32'd0;   wstrb_q <= 4'd0;
      awready_q  <= 1'b1;     wready_q  <= 1'b1;    arready_q <= 1'b1;
      bvalid_q   <= 1'b0;     bresp_q   <= RESP_OKAY;
      rvalid_q   <= 1'b0;     rresp_q   <= RESP_OKAY; rdata_q <= 32'd0;
      mtime_q    <= 64'd0;    mtimecmp_q <= '1;
      cnt_en_q   <= CNT_EN_RST;
      pre_q      <= 16'd0;    irq_q     <= 1'b0;
`ifdef HSV_CLINT_MSIP_EN
      msip_q     <= 1'b0;
`endif
    end else begin
      w_state_q  <= w_state_d;  r_state_q <= r_state_d;
      aw_held_q  <= aw_held_d;  w_held_q  <= w_held_d;
      awaddr_q   <= awaddr_d;   wdata_q   <= wdata_d;   wstrb_q <= wstrb_d;
      awready_q  <= awready_d;  wready_q  <= wready_d;  arready_q <= arready_d;
      bvalid_q   <= bvalid_d;   bresp_q   <= bresp_d;
      rvalid_q   <= rvalid_d;   rresp_q   <= rresp_d;   rdata_q <= rdata_d;
      mtime_q    <= mtime_d;    mtimecmp_q <= mtimecmp_d;
      cnt_en_q   <= cnt_en_d;
      pre_q      <= pre_d;      irq_q     <= irq_d;
`ifdef HSV_CLINT_MSIP_EN
      msip_q     <= msip_d;
`endif
    end
  end

  assign ctrl.awready = awready_q;
  assign ctrl.wready  = wready_q;
  assign ctrl.bvalid  = bvalid_q;
  assign ctrl.bresp   = bresp_q;
  assign ctrl.arready = arready_q;
  assign ctrl.rvalid  = rvalid_q;
  assign ctrl.rresp   = rresp_q;
  assign ctrl.rdata   = rdata_q;
  assign irq_core     = irq_q;

endmodule

// File: tb/tb_hsv_clint_timer.sv
module tb_hsv_clint_timer;
  localparam int         PRE    = 4;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk_core = 1'b0;
  logic rst_core_n = 1'b0;
  logic irq_core;

  axil_if ifc();

  hsv_clint_timer #(.PRESCALE(PRE), .CNT_EN_RST(1'b1)) u_dut (
    .clk_core   (clk_core),
    .rst_core_n (rst_core_n),
    .ctrl       (ifc),
    .irq_core   (irq_core)
  );

  always #5 clk_core = ~clk_core;

  int cyc = 0;
  always @(posedge clk_core) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mtime reference: value mt_base at edge mt_cyc, +1 every PRE edges while enabled
  logic [63:0] mt_base;
  int          mt_cyc;
  bit          mt_en;
  int          wr_cyc;
  logic        irq_c;

  function automatic logic [63:0] exp_mt(input int c);
    return mt_en ? mt_base + 64'((c - mt_cyc) / PRE) : mt_base;
  endfunction

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic [1:0]  resp;
  } sb_t;
  sb_t sb[$];

  always @(negedge clk_core) begin
    sb_t e;
    if (rst_core_n && ifc.rvalid) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
      else begin
        e = sb.pop_front();
        chk({e.tag, "_data"}, 64'(ifc.rdata), 64'(e.data));
        chk({e.tag, "_resp"}, 64'(ifc.rresp), 64'(e.resp));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_core);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic do_reset(input int n);
    rst_core_n = 1'b0;
    step(n);
    rst_core_n = 1'b1;
    mt_base = 64'd0; mt_cyc = cyc; mt_en = 1'b1;
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic [1:0] resp);
    logic [63:0] cur;
    int n;
    cur = exp_mt(cyc);
    ifc.awaddr = addr; ifc.awvalid = 1'b1;
    ifc.wdata = data;  ifc.wstrb = strb; ifc.wvalid = 1'b1;
    ifc.bready = 1'b1;
    step(1);
    ifc.awvalid = 1'b0; ifc.wvalid = 1'b0;
    n = 0;
    while (!ifc.bvalid && n < 20) begin step(1); n++; end
    wr_cyc = cyc;
    irq_c  = irq_core;
    chk({tag, "_bvalid"}, 64'(ifc.bvalid), 64'd1);
    chk({tag, "_bresp"}, 64'(ifc.bresp), 64'(resp));
    if (resp == OKAY) begin
      case (addr)
        32'h00: begin mt_base = {cur[63:32], data}; mt_cyc = wr_cyc; end
        32'h04: begin mt_base = {data, cur[31:0]}; mt_cyc = wr_cyc; end
        32'h10: begin
          if (!data[0] && mt_en) begin mt_base = exp_mt(wr_cyc); mt_en = 1'b0; end
          else if (data[0] && !mt_en) begin mt_en = 1'b1; mt_cyc = wr_cyc; end
        end
        default: ;
      endcase
    end
    step(1);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] data,
                    input logic [1:0] resp);
    sb_t e;
    int n;
    n = 0;
    while (!ifc.arready && n < 20) begin step(1); n++; end
    e.tag = tag; e.data = data; e.resp = resp;
    sb.push_back(e);
    ifc.araddr = addr; ifc.arvalid = 1'b1;
    step(1);
    ifc.arvalid = 1'b0;
    step(1);
  endtask

  task automatic rd_mt(input string tag, input bit hi);
    logic [63:0] e;
    e = exp_mt(cyc);
    rd(tag, hi ? 32'h4 : 32'h0, hi ? e[63:32] : e[31:0], OKAY);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    ifc.awaddr = '0; ifc.awvalid = 1'b0; ifc.wdata = '0; ifc.wstrb = '0;
    ifc.wvalid = 1'b0; ifc.bready = 1'b1; ifc.araddr = '0; ifc.arvalid = 1'b0;
    ifc.rready = 1'b1;
    mt_base = '0; mt_cyc = 0; mt_en = 1'b1;

    // 1: reset state and free-running count
    do_reset(4);
    chk("rst_state", 64'({irq_core, ifc.awready, ifc.wready, ifc.arready, ifc.bvalid, ifc.rvalid}),
        64'(6'b011100));
    rd_mt("t1_mt_a", 1'b0);
    step(8);
    rd_mt("t1_mt_b", 1'b0);
    rd("t1_cmp_lo", 32'h08, 32'hFFFF_FFFF, OKAY);
    rd("t1_cmp_hi", 32'h0C, 32'hFFFF_FFFF, OKAY);
    rd("t1_ctrl",   32'h10, 32'h1, OKAY);
    chk("t1_irq", 64'(irq_core), 64'd0);

    // 2: prescale and freeze
    wr("t2_wr_mt", 32'h00, 32'h0, 4'hF, OKAY);
    step(39);
    rd_mt("t2_mt40", 1'b0);
    wr("t2_stop", 32'h10, 32'h0, 4'hF, OKAY);
    step(20);
    rd_mt("t2_frozen", 1'b0);
    rd("t2_ctrl0", 32'h10, 32'h0, OKAY);
    wr("t2_start", 32'h10, 32'h1, 4'hF, OKAY);

    // 3: irq rise at mtime==mtimecmp, fall when mtimecmp raised
    wr("t3_cmp_hi", 32'h0C, 32'h0, 4'hF, OKAY);
    wr("t3_cmp_lo", 32'h08, 32'd100, 4'hF, OKAY);
    wr("t3_mt", 32'h00, 32'd95, 4'hF, OKAY);
    wait_to(mt_cyc + 20);
    chk("t3_irq_before", 64'(irq_core), 64'd0);
    step(1);
    chk("t3_irq_rise", 64'(irq_core), 64'd1);
    rd_mt("t3_mt_rd", 1'b0);
    wr("t3_cmp_raise", 32'h08, 32'hFFFF_FFFF, 4'hF, OKAY);
    chk("t3_irq_at_commit", 64'(irq_c), 64'd1);
    chk("t3_irq_fall", 64'(irq_core), 64'd0);

    // 4: 64-bit wrap with mtimecmp all ones
    wr("t4_cmp_hi", 32'h0C, 32'hFFFF_FFFF, 4'hF, OKAY);
    wr("t4_mt_hi", 32'h04, 32'hFFFF_FFFF, 4'hF, OKAY);
    wr("t4_mt_lo", 32'h00, 32'hFFFF_FFFE, 4'hF, OKAY);
    wait_to(mt_cyc + 4);
    chk("t4_irq_fe", 64'(irq_core), 64'd0);
    step(1);
    chk("t4_irq_ones", 64'(irq_core), 64'd1);
    wait_to(mt_cyc + 8);
    chk("t4_irq_ones_end", 64'(irq_core), 64'd1);
    step(1);
    chk("t4_irq_wrapped", 64'(irq_core), 64'd0);
    wait_to(mt_cyc + 12);
    rd("t4_mt_lo_rd", 32'h00, 32'h1, OKAY);
    rd("t4_mt_hi_rd", 32'h04, 32'h0, OKAY);

    // 5: W before AW, stalled bready, byte strobes
    ifc.bready = 1'b0;
    ifc.wdata = 32'h1122_3344; ifc.wstrb = 4'hF; ifc.wvalid = 1'b1;
    step(1);
    ifc.wvalid = 1'b0;
    chk("t5_wready_drop", 64'(ifc.wready), 64'd0);
    step(4);
    chk("t5_no_early_b", 64'(ifc.bvalid), 64'd0);
    ifc.awaddr = 32'h08; ifc.awvalid = 1'b1;
    step(1);
    ifc.awvalid = 1'b0;
    cnt = 0;
    repeat (8) begin
      if (ifc.bvalid) cnt++;
      step(1);
    end
    chk("t5_bvalid_hold", 64'(cnt), 64'd8);
    chk("t5_awready_resp", 64'(ifc.awready), 64'd0);
    ifc.bready = 1'b1;
    step(1);
    chk("t5_b_done", 64'({ifc.bvalid, ifc.awready, ifc.wready}), 64'(3'b011));
    rd("t5_cmp_lo", 32'h08, 32'h1122_3344, OKAY);
    rd("t5_cmp_hi", 32'h0C, 32'hFFFF_FFFF, OKAY);
    wr("t5_strb", 32'h08, 32'hAABB_CCDD, 4'b0010, OKAY);
    rd("t5_strb_rd", 32'h08, 32'h1122_CC44, OKAY);

    // 6: read vs same-cycle write, unmapped, MSIP, reset in W_RESP
    begin
      sb_t e;
      e.tag = "t6_rd_old"; e.data = 32'h1122_CC44; e.resp = OKAY;
      sb.push_back(e);
      ifc.awaddr = 32'h08; ifc.awvalid = 1'b1;
      ifc.wdata = 32'h5566_7788; ifc.wstrb = 4'hF; ifc.wvalid = 1'b1;
      ifc.araddr = 32'h08; ifc.arvalid = 1'b1;
      step(1);
      ifc.awvalid = 1'b0; ifc.wvalid = 1'b0; ifc.arvalid = 1'b0;
      step(1);
    end
    rd("t6_rd_new", 32'h08, 32'h5566_7788, OKAY);
    rd("t6_unmapped_rd", 32'h1C, 32'h0, SLVERR);
`ifdef HSV_CLINT_MSIP_EN
    wr("t6_msip", 32'h14, 32'h1, 4'hF, OKAY);
    chk("t6_msip_irq", 64'(irq_core), 64'd1);
    rd("t6_msip_rd", 32'h14, 32'h1, OKAY);
`else
    wr("t6_msip", 32'h14, 32'h1, 4'hF, SLVERR);
    chk("t6_msip_irq", 64'(irq_core), 64'd0);
    rd("t6_msip_rd", 32'h14, 32'h0, SLVERR);
`endif
    ifc.bready = 1'b0;
    ifc.awaddr = 32'h08; ifc.awvalid = 1'b1;
    ifc.wdata = 32'h0; ifc.wstrb = 4'hF; ifc.wvalid = 1'b1;
    step(1);
    ifc.awvalid = 1'b0; ifc.wvalid = 1'b0;
    chk("t6_bvalid_pre_rst", 64'(ifc.bvalid), 64'd1);
    rst_core_n = 1'b0;
    step(1);
    chk("t6_bvalid_rst", 64'(ifc.bvalid), 64'd0);
    ifc.bready = 1'b1;
    do_reset(2);
    chk("t6_rst_state", 64'({irq_core, ifc.awready, ifc.wready, ifc.arready, ifc.bvalid, ifc.rvalid}),
        64'(6'b011100));
    rd("t6_cmp_lo_rst", 32'h08, 32'hFFFF_FFFF, OKAY);
    rd_mt("t6_mt_rst", 1'b0);

    step(3);
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
